// File: rtl/key_command_decoder.sv
// Pushbutton front end: synchronizes, debounces and edge-detects active-low keys,
// auto-repeats direction keys and issues guarded single-cycle command strobes.
module key_command_decoder #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned REPEAT_DELAY    = 25000000,
   parameter int unsigned REPEAT_PERIOD   = 7500000,
   parameter int unsigned CNT_W           = 25
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [4:0] key_n,
   input  logic       busy,
   output logic       enterEn,
   output logic       moveUpEn,
   output logic       moveDownEn,
   output logic       moveLeftEn,
   output logic       moveRightEn,
   output logic [7:0] drop_count
);

   // Codes equal the key bit index so the issued pulse is a plain shift.
   typedef enum logic [2:0] {
      CMD_RIGHT = 3'd0,
      CMD_LEFT  = 3'd1,
      CMD_DOWN  = 3'd2,
      CMD_UP    = 3'd3,
      CMD_ENTER = 3'd4
   } cmd_e;

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DELAY_C  = CNT_W'(REPEAT_DELAY);
   localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(REPEAT_PERIOD);

   logic [4:0]       sync1, sync2, raw, stable, stable_q, press, events;
   logic [CNT_W-1:0] deb_cnt [5];
   logic [CNT_W-1:0] hold_cnt [4];
   logic [3:0]       repeating, fire;
   logic             win_valid, pend_valid, issue, accept;
   cmd_e             win_code, pend_code;
   logic [2:0]       ev_count, drop_add;
   logic [8:0]       drop_sum;
   logic [1:0]       guard;
   logic [4:0]       pulse;

   assign raw   = ~sync2;
   assign press = stable & ~stable_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync1    <= '1;
         sync2    <= '1;
         stable   <= '0;
         stable_q <= '0;
         for (int unsigned i = 0; i < 5; i++) deb_cnt[i] <= '0;
      end else begin
         sync1    <= key_n;
         sync2    <= sync1;
         stable_q <= stable;
         for (int unsigned i = 0; i < 5; i++) begin
            if (raw[i] == stable[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DEB_LAST) begin
               stable[i]  <= raw[i];
               deb_cnt[i] <= '0;
            end else begin
               deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // hold_cnt is 0 in the press cycle and counts cycles since the last event.
   always_comb begin
      fire = '0;
      for (int unsigned i = 0; i < 4; i++)
         fire[i] = stable[i] && (hold_cnt[i] == (repeating[i] ? PERIOD_C : DELAY_C));
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         repeating <= '0;
         for (int unsigned i = 0; i < 4; i++) hold_cnt[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (!stable[i]) begin
               hold_cnt[i]  <= '0;
               repeating[i] <= 1'b0;
            end else if (fire[i]) begin
               hold_cnt[i]  <= CNT_W'(1);
               repeating[i] <= 1'b1;
            end else begin
               hold_cnt[i] <= hold_cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   assign events = press | {1'b0, fire};

   always_comb begin
      win_valid = |events;
      win_code  = CMD_RIGHT;
      ev_count  = '0;
      if (events[4])      win_code = CMD_ENTER;
      else if (events[3]) win_code = CMD_UP;
      else if (events[2]) win_code = CMD_DOWN;
      else if (events[1]) win_code = CMD_LEFT;
      for (int unsigned i = 0; i < 5; i++) ev_count = ev_count + {2'b00, events[i]};
   end

   assign issue    = pend_valid && !busy && (guard == 2'd0);
   assign accept   = win_valid && (!pend_valid || issue);
   assign drop_add = accept ? (ev_count - 3'd1) : ev_count;
   assign drop_sum = {1'b0, drop_count} + {6'b000000, drop_add};

   // guard spans the pulse cycle and the one after it, spacing pulses 3 cycles apart.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pend_valid <= 1'b0;
         pend_code  <= CMD_RIGHT;
         guard      <= '0;
         pulse      <= '0;
         drop_count <= '0;
      end else begin
         if (accept) begin
            pend_valid <= 1'b1;
            pend_code  <= win_code;
         end else if (issue) begin
            pend_valid <= 1'b0;
         end
         if (issue)               guard <= 2'd2;
         else if (guard != 2'd0)  guard <= guard - 2'd1;
         pulse      <= issue ? (5'b00001 << pend_code) : '0;
         drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      end
   end

   assign enterEn     = pulse[4];
   assign moveUpEn    = pulse[3];
   assign moveDownEn  = pulse[2];
   assign moveLeftEn  = pulse[1];
   assign moveRightEn = pulse[0];

endmodule
